// File: rtl/demux4_capture.sv
// Registered 1-to-4 capture bank: routes din into one of four holding registers
// selected by sel or by an auto-increment pointer, with per-channel valid flags.
module demux4_capture #(
    parameter int WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     din,
    input  logic [1:0]           sel,
    input  logic                 wr_en,
    input  logic                 auto,
    input  logic                 clr,
    output logic [4*WIDTH-1:0]   dout,
    output logic [3:0]           valid,
    output logic [1:0]           ptr,
    output logic                 all_valid,
    output logic                 frame_done
);

    logic [WIDTH-1:0] ch_q [4];
    logic [WIDTH-1:0] ch_d [4];
    logic [3:0]       valid_q, valid_d;
    logic [1:0]       ptr_q, ptr_d;
    logic             fd_q, fd_d;
    logic [1:0]       tgt;

    assign tgt = auto ? ptr_q : sel;

    always_comb begin
        ch_d    = ch_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        fd_d    = 1'b0;
        // clr wins over a simultaneous write; that write is dropped
        if (clr) begin
            for (int i = 0; i < 4; i++) ch_d[i] = '0;
            valid_d = 4'b0000;
            ptr_d   = 2'd0;
        end else if (wr_en) begin
            ch_d[tgt]    = din;
            valid_d[tgt] = 1'b1;
            if (auto) begin
                ptr_d = ptr_q + 2'd1;
                fd_d  = (ptr_q == 2'd3);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) ch_q[i] <= '0;
            valid_q <= 4'b0000;
            ptr_q   <= 2'd0;
            fd_q    <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) ch_q[i] <= ch_d[i];
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            fd_q    <= fd_d;
        end
    end

    // Same layout as the 4-to-1 mux input: ch0 occupies the top slice
    assign dout       = {ch_q[0], ch_q[1], ch_q[2], ch_q[3]};
    assign valid      = valid_q;
    assign ptr        = ptr_q;
    assign all_valid  = &valid_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_demux4_capture.sv
// Bench for demux4_capture: directed test-plan steps plus random traffic,
// compared against a channel-array reference model.
module tb_demux4_capture;

    localparam int W = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   din;
    logic [1:0]     sel;
    logic           wr_en;
    logic           auto;
    logic           clr;
    logic [4*W-1:0] dout;
    logic [3:0]     valid;
    logic [1:0]     ptr;
    logic           all_valid;
    logic           frame_done;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int mch [4];
    int mval [4];
    int mptr;
    int mfd;

    demux4_capture #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .din(din), .sel(sel), .wr_en(wr_en),
        .auto(auto), .clr(clr), .dout(dout), .valid(valid), .ptr(ptr),
        .all_valid(all_valid), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mch[i]  = 0;
            mval[i] = 0;
        end
        mptr = 0;
        mfd  = 0;
    endtask

    function automatic logic [31:0] exp_dout();
        logic [31:0] r = 0;
        for (int i = 0; i < 4; i++) r = r + (32'(mch[i]) << ((3 - i) * W));
        return r;
    endfunction

    function automatic logic [31:0] exp_valid();
        logic [31:0] r = 0;
        for (int i = 0; i < 4; i++) if (mval[i] != 0) r = r + (32'd1 << i);
        return r;
    endfunction

    function automatic logic [W-1:0] mux4(input logic [4*W-1:0] packed_in, input logic [1:0] s);
        return packed_in[(3 - int'(s)) * W +: W];
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".dout"},  32'(dout),       exp_dout());
        chk({tag, ".valid"}, 32'(valid),      exp_valid());
        chk({tag, ".ptr"},   32'(ptr),        32'(mptr));
        chk({tag, ".allv"},  32'(all_valid),  32'((mval[0] & mval[1] & mval[2] & mval[3]) != 0));
        chk({tag, ".fd"},    32'(frame_done), 32'(mfd));
    endtask

    // Drive at a falling edge, let one rising edge pass, check at the next falling edge
    task automatic step(input logic w, input logic [1:0] s, input logic [W-1:0] d,
                        input logic a, input logic c, input string tag);
        int t;
        wr_en = w; sel = s; din = d; auto = a; clr = c;
        @(posedge clk);
        if (c) begin
            model_reset();
        end else if (w) begin
            t = a ? mptr : int'(s);
            mch[t]  = int'(d);
            mval[t] = 1;
            mfd     = (a && mptr == 3) ? 1 : 0;
            if (a) mptr = (mptr + 1) % 4;
        end else begin
            mfd = 0;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        reset = 1'b1; din = '0; sel = '0; wr_en = 1'b0; auto = 1'b0; clr = 1'b0;
        model_reset();
        #1;
        check_all("por");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all("idle");

        // Manual writes
        step(1'b1, 2'd2, 2'b01, 1'b0, 1'b0, "man0");
        step(1'b1, 2'd0, 2'b11, 1'b0, 1'b0, "man1");
        chk("man.dout_const", 32'(dout), 32'b11_00_01_00);
        chk("man.valid_const", 32'(valid), 32'b0101);

        // Auto frame
        step(1'b1, 2'd3, 2'b10, 1'b1, 1'b0, "af0");
        step(1'b1, 2'd3, 2'b01, 1'b1, 1'b0, "af1");
        step(1'b1, 2'd0, 2'b11, 1'b1, 1'b0, "af2");
        step(1'b1, 2'd1, 2'b00, 1'b1, 1'b0, "af3");
        chk("af.fd_pulse", 32'(frame_done), 32'd1);
        chk("af.dout_const", 32'(dout), 32'b10_01_11_00);
        chk("af.ptr_wrap", 32'(ptr), 32'd0);
        chk("rt.sel0", 32'(mux4(dout, 2'd0)), 32'b10);
        chk("rt.sel1", 32'(mux4(dout, 2'd1)), 32'b01);
        chk("rt.sel2", 32'(mux4(dout, 2'd2)), 32'b11);
        chk("rt.sel3", 32'(mux4(dout, 2'd3)), 32'b00);
        step(1'b0, 2'd0, 2'b00, 1'b1, 1'b0, "af_idle");
        chk("af.fd_once", 32'(frame_done), 32'd0);

        // clr beats a simultaneous write
        step(1'b1, 2'd1, 2'b11, 1'b0, 1'b1, "clrw");
        chk("clrw.dout_zero", 32'(dout), 32'd0);
        step(1'b1, 2'd3, 2'b10, 1'b1, 1'b0, "clrw_next");
        chk("clrw.ch0", 32'(valid), 32'b0001);

        // Mode switch mid-frame
        step(1'b0, 2'd0, 2'b00, 1'b0, 1'b1, "ms_clr");
        step(1'b1, 2'd0, 2'b01, 1'b1, 1'b0, "ms0");
        step(1'b1, 2'd0, 2'b11, 1'b1, 1'b0, "ms1");
        step(1'b1, 2'd3, 2'b01, 1'b0, 1'b0, "ms_man");
        chk("ms.ptr_hold", 32'(ptr), 32'd2);
        step(1'b1, 2'd0, 2'b10, 1'b1, 1'b0, "ms2");
        chk("ms.ch2", 32'(mux4(dout, 2'd2)), 32'b10);
        chk("ms.ch3", 32'(mux4(dout, 2'd3)), 32'b01);
        chk("ms.ptr3", 32'(ptr), 32'd3);
        chk("ms.fd0", 32'(frame_done), 32'd0);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            step(1'($urandom_range(0, 3) != 0), 2'($urandom), W'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0), "rnd");
        end

        // Asynchronous reset mid-frame, observed before any clock edge
        step(1'b1, 2'd1, 2'b11, 1'b0, 1'b0, "pre_rst");
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clk);
        check_all("rst_hold");
        reset = 1'b0;
        step(1'b1, 2'd2, 2'b10, 1'b1, 1'b0, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux4_capture.md
Name: demux4_capture

Overview:
- Registered 1-to-4 demultiplexer/capture bank, the receiving end of the team's 4-to-1 channel multiplexer.
- Routes a WIDTH-bit input word into one of four holding registers, selected either by an explicit select or by an internal auto-increment pointer.
- Tracks per-channel valid flags and signals frame completion.
- Packed output uses the same layout as the multiplexer input: a 4-to-1 mux driven by the same select returns the captured word.

Parameters:
WIDTH, 2, bit width of each channel word (≥1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
din  input  WIDTH  data word to capture
sel  input  2  explicit channel index (used when auto=0)
wr_en  input  1  capture strobe, one word per cycle
auto  input  1  1 = use internal pointer, 0 = use sel
clr  input  1  synchronous clear of flags, pointer and data
dout  output  4*WIDTH  packed channels: ch0 at [4W-1:3W], ch1 at [3W-1:2W], ch2 at [2W-1:W], ch3 at [W-1:0]
valid  output  4  valid[i]=1 once channel i written since last clear
ptr  output  2  current auto pointer value
all_valid  output  1  &valid
frame_done  output  1  one-cycle pulse on auto-mode write to channel 3

Behaviour:
- Single clock domain; all state updates on rising clk.
- Reset (async, active-high): dout=0, valid=4'b0000, ptr=0, frame_done=0; holds while reset=1.
- Target index: tgt = auto ? ptr : sel, sampled in the same cycle as wr_en.
- Write (wr_en=1, clr=0): channel tgt ← din and valid[tgt] ← 1 at the next edge. Latency is 1 cycle; dout/valid reflect the write in the cycle after the strobe.
- Other channels hold their values. Rewriting an already-valid channel overwrites its data; the flag stays 1.
- Pointer:
  - increments mod 4 on every write with auto=1 (3→0 wrap).
  - unchanged on writes with auto=0, and on cycles with wr_en=0.
- frame_done: registered, 1 for exactly the cycle after an auto-mode write with ptr=3, otherwise 0.
- all_valid: combinational AND of the registered valid bits.
- clr=1: at the next edge, all channels ← 0, valid ← 0, ptr ← 0, frame_done ← 0. clr has priority over a simultaneous wr_en; that write is discarded.
- Toggling auto mid-frame: the pointer keeps its value; manual writes do not disturb it.
- Reset asserted mid-frame: immediate return to reset values; there is no partial-frame recovery.
- No backpressure. Every wr_en cycle is accepted.

Test Plan:
- Reset: assert reset with prior data present → dout=0, valid=0000, ptr=0, frame_done=0 without waiting for a clock edge.
- Manual writes (WIDTH=2, auto=0): din=01 sel=2; din=11 sel=0 → dout=8'b11_00_01_00, valid=0101, ptr=0, all_valid=0.
- Auto frame: auto=1, four consecutive writes 10,01,11,00 → dout=8'b10_01_11_00, valid=1111, all_valid=1. frame_done pulses exactly once, in the cycle after the 4th write, and ptr returns to 0.
- Mux round-trip: after the auto frame, feed dout and each sel 0..3 into the 4-to-1 multiplexer → outputs 10,01,11,00 respectively.
- clr vs write: clr=1 and wr_en=1 (din=11) in the same cycle → next cycle dout=0, valid=0000, ptr=0. A subsequent auto write lands in ch0.
- Mode switch: auto=1, two writes (ptr=2); auto=0 write sel=3 din=01 (ptr stays 2); auto=1 write din=10 → ch2=10, ch3=01, ptr=3, frame_done=0.
